// File: rtl/bellek_asamasi_pkg.sv
// rtl/bellek_asamasi_pkg.sv - shared constants for the memory stage
// Purpose : load/store funct3 encodings and memory-stage FSM states.
// Ports   : none (package).
package bellek_paket;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      ISTEK = 2'd1,
      YANIT = 2'd2,
      TAMAM = 2'd3
   } durum_t;

endpackage

// File: rtl/bellek_asamasi_yukleme_hizalayici.sv
// rtl/bellek_asamasi_yukleme_hizalayici.sv - load lane select and extension
// Purpose : picks the byte/half addressed by adres_alt_i out of a read word
//           and sign- or zero-extends it according to the load type.
// Ports   : kelime_i    read word from memory
//           adres_alt_i address bits [1:0] of the load
//           tip_i       load funct3
//           sonuc_o     32-bit value for write-back
module yukleme_hizalayici
   import bellek_paket::*;
(
   input  logic [31:0] kelime_i,
   input  logic [1:0]  adres_alt_i,
   input  logic [2:0]  tip_i,
   output logic [31:0] sonuc_o
);

   logic [7:0]  bayt;
   logic [15:0] yarim;

   always_comb begin
      bayt    = 8'h00;
      yarim   = 16'h0000;
      sonuc_o = kelime_i;
      case (adres_alt_i)
         2'd0:    bayt = kelime_i[7:0];
         2'd1:    bayt = kelime_i[15:8];
         2'd2:    bayt = kelime_i[23:16];
         default: bayt = kelime_i[31:24];
      endcase
      // Halves are always 2-byte aligned here, so only bit 1 selects.
      yarim = adres_alt_i[1] ? kelime_i[31:16] : kelime_i[15:0];
      case (tip_i)
         LS_B:    sonuc_o = {{24{bayt[7]}}, bayt};
         LS_BU:   sonuc_o = {24'h000000, bayt};
         LS_H:    sonuc_o = {{16{yarim[15]}}, yarim};
         LS_HU:   sonuc_o = {16'h0000, yarim};
         default: sonuc_o = kelime_i;
      endcase
   end

endmodule

// File: rtl/bellek_asamasi.sv
// rtl/bellek_asamasi.sv - pipeline memory stage with valid/ready data port
// Purpose : takes load/store requests from execute, issues word-aligned
//           requests to data memory, aligns load data, registers the result
//           toward write-back, stalls while an access is in flight and
//           reports misaligned or timed-out accesses.
// Ports   : clk_i/rst_i                   clock, async active-low reset
//           durdur_i                      global pipeline hold
//           bellek_*_i, load_save_*_i     access from execute
//           hedef_*_i, yazmaca_yaz_i      write-back controls from execute
//           veri_istek_*                  request channel to memory
//           veri_yanit_*                  read-data channel from memory
//           bellek_stall_o                hold upstream stages
//           hata_o/hata_adres_o           fault pulse and faulting address
//           hedef_*_o, yazmaca_yaz_o      registered result to write-back
module bellek_asamasi #(
   parameter int BEKLEME_SINIRI = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        durdur_i,
   input  logic [31:0] bellek_adresi_i,
   input  logic [31:0] bellek_veri_i,
   input  logic [2:0]  load_save_buyrugu_i,
   input  logic        bellekten_oku_i,
   input  logic        bellege_yaz_i,
   input  logic [31:0] hedef_yazmac_verisi_i,
   input  logic        yazmaca_yaz_i,
   input  logic [4:0]  hedef_yazmaci_i,
   output logic        veri_istek_gecerli_o,
   input  logic        veri_istek_hazir_i,
   output logic [31:0] veri_istek_adres_o,
   output logic        veri_istek_yaz_o,
   output logic [3:0]  veri_istek_maske_o,
   output logic [31:0] veri_istek_veri_o,
   input  logic        veri_yanit_gecerli_i,
   input  logic [31:0] veri_yanit_veri_i,
   output logic        bellek_stall_o,
   output logic        hata_o,
   output logic [31:0] hata_adres_o,
   output logic [31:0] hedef_yazmac_verisi_o,
   output logic        yazmaca_yaz_o,
   output logic [4:0]  hedef_yazmaci_o
);
   import bellek_paket::*;

   localparam int SAYAC_W = (BEKLEME_SINIRI > 1) ? $clog2(BEKLEME_SINIRI) : 1;
   localparam logic [SAYAC_W-1:0] SON_SAYI = SAYAC_W'(BEKLEME_SINIRI - 1);

   durum_t durum_q, durum_d;

   logic [31:0]        adres_q;
   logic [3:0]         maske_q;
   logic [31:0]        veri_q;
   logic [2:0]         tip_q;
   logic [4:0]         rd_q;
   logic               yazma_q;
   logic               wb_en_q;
   logic [31:0]        sonuc_q;   // park buffer for the finished access
   logic [SAYAC_W-1:0] sayac_q;

   logic [31:0] hdv_q;
   logic        yy_q;
   logic [4:0]  hr_q;
   logic        hata_q;
   logic [31:0] hata_adres_q;

   logic        mem_op, hizasiz, hizali_op, zaman_asimi;
   logic [3:0]  maske_d;
   logic [31:0] veri_d;
   logic [31:0] hizali_veri;

   assign mem_op    = bellekten_oku_i | bellege_yaz_i;
   assign hizali_op = mem_op & ~hizasiz;
   assign zaman_asimi = (BEKLEME_SINIRI != 0) && (sayac_q == SON_SAYI);

   always_comb begin
      hizasiz = 1'b0;
      case (load_save_buyrugu_i)
         LS_B, LS_BU: hizasiz = 1'b0;
         LS_H, LS_HU: hizasiz = bellek_adresi_i[0];
         default:     hizasiz = (bellek_adresi_i[1:0] != 2'b00);
      endcase
   end

   // Store lanes: narrow data is replicated so the strobes alone pick the lane.
   always_comb begin
      maske_d = 4'b1111;
      veri_d  = 32'h0000_0000;
      if (bellege_yaz_i) begin
         case (load_save_buyrugu_i)
            LS_B, LS_BU: begin
               maske_d = 4'b0001 << bellek_adresi_i[1:0];
               veri_d  = {4{bellek_veri_i[7:0]}};
            end
            LS_H, LS_HU: begin
               maske_d = 4'b0011 << bellek_adresi_i[1:0];
               veri_d  = {2{bellek_veri_i[15:0]}};
            end
            default: veri_d = bellek_veri_i;
         endcase
      end
   end

   yukleme_hizalayici u_hizalayici (
      .kelime_i    (veri_yanit_veri_i),
      .adres_alt_i (adres_q[1:0]),
      .tip_i       (tip_q),
      .sonuc_o     (hizali_veri)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) durum_q <= BOSTA;
      else        durum_q <= durum_d;
   end

   always_comb begin
      durum_d              = durum_q;
      veri_istek_gecerli_o = 1'b0;
      bellek_stall_o       = 1'b0;
      case (durum_q)
         BOSTA: begin
            bellek_stall_o = hizali_op;
            if (hizali_op && !durdur_i) durum_d = ISTEK;
         end
         ISTEK: begin
            veri_istek_gecerli_o = 1'b1;
            bellek_stall_o       = 1'b1;
            if (veri_istek_hazir_i) begin
               // A response in the handshake cycle means zero-latency memory.
               if (yazma_q || veri_yanit_gecerli_i) durum_d = TAMAM;
               else                                 durum_d = YANIT;
            end else if (zaman_asimi) begin
               durum_d = BOSTA;
            end
         end
         YANIT: begin
            bellek_stall_o = 1'b1;
            if (veri_yanit_gecerli_i) durum_d = TAMAM;
            else if (zaman_asimi)     durum_d = BOSTA;
         end
         TAMAM: begin
            bellek_stall_o = durdur_i;
            if (!durdur_i) durum_d = BOSTA;
         end
         default: durum_d = BOSTA;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         adres_q      <= '0;
         maske_q      <= '0;
         veri_q       <= '0;
         tip_q        <= '0;
         rd_q         <= '0;
         yazma_q      <= 1'b0;
         wb_en_q      <= 1'b0;
         sonuc_q      <= '0;
         sayac_q      <= '0;
         hdv_q        <= '0;
         yy_q         <= 1'b0;
         hr_q         <= '0;
         hata_q       <= 1'b0;
         hata_adres_q <= '0;
      end else begin
         hata_q <= 1'b0;

         if ((durum_q == ISTEK || durum_q == YANIT) && durum_d == durum_q)
            sayac_q <= sayac_q + SAYAC_W'(1);
         else
            sayac_q <= '0;

         case (durum_q)
            BOSTA: begin
               if (!durdur_i) begin
                  if (hizali_op) begin
                     adres_q <= bellek_adresi_i;
                     maske_q <= maske_d;
                     veri_q  <= veri_d;
                     tip_q   <= load_save_buyrugu_i;
                     rd_q    <= hedef_yazmaci_i;
                     yazma_q <= bellege_yaz_i;
                     wb_en_q <= yazmaca_yaz_i;
                  end else if (mem_op) begin
                     hata_q       <= 1'b1;
                     hata_adres_q <= bellek_adresi_i;
                     hdv_q        <= hedef_yazmac_verisi_i;
                     yy_q         <= 1'b0;
                     hr_q         <= hedef_yazmaci_i;
                  end else begin
                     hdv_q <= hedef_yazmac_verisi_i;
                     yy_q  <= yazmaca_yaz_i;
                     hr_q  <= hedef_yazmaci_i;
                  end
               end
            end
            ISTEK: begin
               if (veri_istek_hazir_i) begin
                  if (yazma_q)                   sonuc_q <= '0;
                  else if (veri_yanit_gecerli_i) sonuc_q <= hizali_veri;
               end else if (zaman_asimi) begin
                  // The faulting instruction must never reach write-back.
                  hata_q       <= 1'b1;
                  hata_adres_q <= adres_q;
                  yy_q         <= 1'b0;
               end
            end
            YANIT: begin
               if (veri_yanit_gecerli_i) begin
                  sonuc_q <= hizali_veri;
               end else if (zaman_asimi) begin
                  hata_q       <= 1'b1;
                  hata_adres_q <= adres_q;
                  yy_q         <= 1'b0;
               end
            end
            TAMAM: begin
               if (!durdur_i) begin
                  hdv_q <= sonuc_q;
                  yy_q  <= wb_en_q & ~yazma_q;
                  hr_q  <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign veri_istek_adres_o    = {adres_q[31:2], 2'b00};
   assign veri_istek_yaz_o      = yazma_q;
   assign veri_istek_maske_o    = maske_q;
   assign veri_istek_veri_o     = veri_q;
   assign hata_o                = hata_q;
   assign hata_adres_o          = hata_adres_q;
   assign hedef_yazmac_verisi_o = hdv_q;
   assign yazmaca_yaz_o         = yy_q;
   assign hedef_yazmaci_o       = hr_q;

endmodule

// File: doc/bellek_asamasi.md
Name: bellek_asamasi

Overview:
- Memory stage directly downstream of the execute stage; consumes its address, store data, load/store type, and write-back controls.
- Issues word-aligned valid/ready requests to the data memory or cache and byte/half-aligns and sign-extends load data.
- Registers the result toward write-back.
- Stalls the pipeline while an access is outstanding and flags misaligned or timed-out accesses.

Parameters:
- BEKLEME_SINIRI, 255: max cycles spent in ISTEK or YANIT before timeout. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- durdur_i  in  1  global pipeline hold
- bellek_adresi_i  in  32  effective address from execute
- bellek_veri_i  in  32  store data
- load_save_buyrugu_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- bellekten_oku_i  in  1  load
- bellege_yaz_i  in  1  store
- hedef_yazmac_verisi_i  in  32  execute result for non-load instructions
- yazmaca_yaz_i  in  1  write-back enable
- hedef_yazmaci_i  in  5  rd
- veri_istek_gecerli_o  out  1  memory request valid
- veri_istek_hazir_i  in  1  memory accepts request
- veri_istek_adres_o  out  32  word address, bits [1:0] = 0
- veri_istek_yaz_o  out  1  1 = write
- veri_istek_maske_o  out  4  byte strobes
- veri_istek_veri_o  out  32  lane-shifted store data
- veri_yanit_gecerli_i  in  1  read data valid
- veri_yanit_veri_i  in  32  read word
- bellek_stall_o  out  1  hold upstream stages
- hata_o  out  1  one-cycle misaligned/timeout pulse
- hata_adres_o  out  32  faulting address
- hedef_yazmac_verisi_o  out  32  to write-back
- yazmaca_yaz_o  out  1  to write-back
- hedef_yazmaci_o  out  5  to write-back

Behaviour:
- Reset values:
  - All outputs 0.
  - State BOSTA.
  - Timeout counter 0.
  - Park buffer empty.
- Reset asserted mid-access: FSM returns to BOSTA asynchronously and the request is dropped without retry.
- Misalignment check in BOSTA (mem op = oku|yaz):
  - H/HU is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]≠0.
  - B/BU is never misaligned.
- Misaligned access:
  - No request is issued.
  - hata_o pulses next cycle with hata_adres_o = addr.
  - Output register takes yazmaca_yaz_o=0.
  - No stall.
- FSM BOSTA:
  - Mem op, aligned, and !durdur_i: latch address/mask/data/type/rd/yaz and go to ISTEK.
  - Otherwise (non-mem), when !durdur_i: output register <= {hedef_yazmac_verisi_i, yazmaca_yaz_i, hedef_yazmaci_i}. Latency 1.
- FSM ISTEK:
  - veri_istek_gecerli_o=1.
  - Address, mask, data, and yaz stay stable until veri_istek_hazir_i.
  - On handshake, a store goes to TAMAM and a load goes to YANIT.
- FSM YANIT:
  - On veri_yanit_gecerli_i, extract the lane at addr[1:0], extend per type, and go to TAMAM.
  - Load result: B/H sign-extended, BU/HU zero-extended, W passed through.
- FSM TAMAM:
  - If !durdur_i: output register <= result (stores take yazmaca_yaz_o=0) and go to BOSTA.
  - Else hold the result in the park buffer until durdur_i falls.
- Store lanes:
  - B: mask 0001<<addr[1:0], data {4{byte}}.
  - H: mask 0011<<addr[1:0], data {2{half}}.
  - W: mask 1111.
  - Load requests drive mask 1111, veri 0.
- bellek_stall_o is combinational:
  - 1 in BOSTA when an aligned mem op is present.
  - 1 in ISTEK and YANIT.
  - 1 in TAMAM while durdur_i=1.
  - 0 on the TAMAM cycle where the output is written; upstream advances on that same edge.
- Timeout:
  - Counter increments each cycle in ISTEK or YANIT and clears on state exit.
  - Reaching BEKLEME_SINIRI: hata_o pulse, hata_adres_o = latched addr, yazmaca_yaz_o=0, return to BOSTA.
  - A late veri_yanit_gecerli_i arriving in BOSTA is ignored.
- Simultaneous events:
  - veri_istek_hazir_i and veri_yanit_gecerli_i in the same ISTEK cycle: the response is accepted (zero-latency memory) and the FSM goes to TAMAM.
  - durdur_i in ISTEK or YANIT does not cancel the access.
- Output register holds while durdur_i=1.

Decomposition:
- Package bellek_paket:
  - funct3 constants LS_B, LS_H, LS_W, LS_BU, LS_HU.
  - State encodings BOSTA, ISTEK, YANIT, TAMAM.
- Sub-module yukleme_hizalayici: combinational lane select and extension from (word, addr[1:0], funct3) -> 32-bit.
- Store mask/shift logic stays inline.

Test Plan:
- Aligned LW, addr 0x100, memory hazir after 2 cycles, yanit after 1 more, word 0xDEADBEEF -> veri_istek_adres_o=0x100; stall high 4 cycles; hedef_yazmac_verisi_o=0xDEADBEEF with yazmaca_yaz_o=1.
- LB vs LBU, addr 0x103, word 0x80FF7F01 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH, addr 0x102, data 0x0000ABCD -> mask 1100, veri_istek_veri_o=0xABCDABCD, veri_istek_yaz_o=1, yazmaca_yaz_o=0.
- LW, addr 0x101 -> no veri_istek_gecerli_o; hata_o one cycle; hata_adres_o=0x101; no stall.
- BEKLEME_SINIRI=4, hazir held 0 -> hata_o after 4 cycles in ISTEK; FSM back to BOSTA; a later yanit is ignored.
- durdur_i=1 during YANIT with the response arriving -> result parked, stall stays high; one cycle after durdur_i falls the output register is updated; rst_i low mid-ISTEK drops gecerli immediately.
